// File: rtl/led_pkg.sv
// Package: led_pkg
// Shared types and segment patterns for the LED scan multiplexer.
//  - seg_t : 7-bit segment vector ordered {a,b,c,d,e,f,g}, active-high form.
//  - SEG_* : active-high patterns for digits 0-9, hex letters A-F, DASH and OFF.
// Polarity inversion for the board pins is applied only at the output
// register in led_scan_mux; everything here is active-high.
package led_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b1111110;
  localparam seg_t SEG_1    = 7'b0110000;
  localparam seg_t SEG_2    = 7'b1101101;
  localparam seg_t SEG_3    = 7'b1111001;
  localparam seg_t SEG_4    = 7'b0110011;
  localparam seg_t SEG_5    = 7'b1011011;
  localparam seg_t SEG_6    = 7'b1011111;
  localparam seg_t SEG_7    = 7'b1110000;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1111011;
  localparam seg_t SEG_A    = 7'b1110111;
  localparam seg_t SEG_B    = 7'b0011111;
  localparam seg_t SEG_C    = 7'b1001110;
  localparam seg_t SEG_D    = 7'b0111101;
  localparam seg_t SEG_E    = 7'b1001111;
  localparam seg_t SEG_F    = 7'b1000111;
  localparam seg_t SEG_DASH = 7'b0000001;
  localparam seg_t SEG_OFF  = 7'b0000000;

endpackage : led_pkg

// File: rtl/led_seg_dec.sv
// Module: led_seg_dec
// Combinational nibble-to-7-segment decoder, active-high output.
//  nib  in   4  value to display
//  seg  out  7  {a,b,c,d,e,f,g}, 1 = segment lit
// Configuration macro LED_HEX_EN:
//  defined   -> 10-15 show A, b, C, d, E, F
//  undefined -> 10-15 show a dash (only segment g)
module led_seg_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import led_pkg::*;

  always_comb begin
    // NOTE: default assignment first so every path drives seg and no latch is inferred.
    seg = SEG_DASH;
    case (nib)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
`ifdef LED_HEX_EN
      4'd10: seg = SEG_A;
      4'd11: seg = SEG_B;
      4'd12: seg = SEG_C;
      4'd13: seg = SEG_D;
      4'd14: seg = SEG_E;
      4'd15: seg = SEG_F;
`else
      default: seg = SEG_DASH;
`endif
    endcase
  end

endmodule : led_seg_dec

// File: rtl/led_scan_mux.sv
// Module: led_scan_mux
// Time-multiplexed driver for an N_DIG-digit common-segment 7-segment display.
// A load captures {data, blank_mask} into a shadow register; the shadow is
// copied to the displayed copy only at the end of a full scan, so a digit
// never shows a half-updated value.
// Ports:
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  load        in   1        capture data/blank_mask this cycle
//  data        in   4*N_DIG  digit i = data[4i+3:4i]; digit 0 is rightmost
//  blank_mask  in   N_DIG    bit i = 1 blanks digit i
//  seg         out  7        {a,b,c,d,e,f,g}, polarity per SEG_ACT_LOW
//  sel         out  N_DIG    one-hot digit select, polarity per SEL_ACT_LOW
//  frame       out  1        1-cycle pulse after the last digit's slot ends
// Configuration macro LED_HEX_EN (consumed by led_seg_dec): hex letters vs dash
// for nibble values 10-15.
module led_scan_mux #(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          SEL_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [4*N_DIG-1:0] data,
  input  logic [N_DIG-1:0]   blank_mask,
  output logic [6:0]         seg,
  output logic [N_DIG-1:0]   sel,
  output logic               frame
);
  import led_pkg::*;

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);

  // XOR masks turn the active-high internal form into pin polarity.
  localparam seg_t             SEG_XOR = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIG-1:0] SEL_XOR = SEL_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        dig_idx;
  logic                    pending;
  logic [N_DIG-1:0][3:0]   shadow_data;
  logic [N_DIG-1:0]        shadow_blank;
  logic [N_DIG-1:0][3:0]   disp_data;
  logic [N_DIG-1:0]        disp_blank;

  logic                    tick;
  logic                    boundary;
  seg_t                    dec_seg;
  seg_t                    seg_next;
  logic [N_DIG-1:0]        sel_next;

  assign tick     = (div_cnt == DIV_MAX);
  assign boundary = tick && (dig_idx == LAST_IDX);

  led_seg_dec u_dec (
    .nib (disp_data[dig_idx]),
    .seg (dec_seg)
  );

  assign seg_next = disp_blank[dig_idx] ? SEG_OFF : dec_seg;
  assign sel_next = {{(N_DIG-1){1'b0}}, 1'b1} << dig_idx;

  // Prescaler and digit scan position.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig_idx <= '0;
      frame   <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      frame   <= boundary;
      if (tick) begin
        dig_idx <= (dig_idx == LAST_IDX) ? '0 : dig_idx + 1'b1;
      end
    end
  end

  // Shadow/display double buffer. The load is written after the boundary
  // transfer so a load in the boundary cycle leaves pending set and waits
  // for the next boundary instead of bypassing straight to the display.
  // NOTE: these are small flop banks, not RAM, and must be reset so the
  // display comes up blank rather than showing power-on garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= 1'b0;
      shadow_data  <= '0;
      shadow_blank <= '1;
      disp_data    <= '0;
      disp_blank   <= '1;
    end else begin
      if (boundary && pending) begin
        disp_data  <= shadow_data;
        disp_blank <= shadow_blank;
        pending    <= 1'b0;
      end
      if (load) begin
        shadow_data  <= data;
        shadow_blank <= blank_mask;
        pending      <= 1'b1;
      end
    end
  end

  // Registered pin drivers; the only place polarity is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF ^ SEG_XOR;
      sel <= SEL_XOR;
    end else begin
      seg <= seg_next ^ SEG_XOR;
      sel <= sel_next ^ SEL_XOR;
    end
  end

endmodule : led_scan_mux
